// File: rtl/booth_pkg.sv
// ============================================================================
//  Module      : booth_pkg
//  Description : Shared FSM state encoding, default parameters and operand
//                pair type for the Booth multiplier operand sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package booth_pkg;

    localparam int DEF_W       = 4;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_TIMEOUT = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    typedef struct packed {
        logic [DEF_W-1:0] x;
        logic [DEF_W-1:0] y;
    } pair_t;

endpackage

`default_nettype wire

// File: rtl/booth_operand_fifo.sv
// ============================================================================
//  Module      : booth_operand_fifo
//  Description : Synchronous FIFO for operand pairs; extra pointer MSB
//                distinguishes full from empty on wrap-around.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module booth_operand_fifo
    import booth_pkg::*;
#(
    parameter type T     = pair_t,
    parameter int  DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  T                       wdata,
    input  logic                   pop,
    output T                       rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW:0]    wptr_q;
    logic [AW:0]    wptr_d;
    logic [AW:0]    rptr_q;
    logic [AW:0]    rptr_d;

    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);
    assign count = wptr_q - rptr_q;
    assign rdata = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push && !full) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop && !empty) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem_q[wptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/booth_operand_sequencer.sv
// ============================================================================
//  Module      : booth_operand_sequencer
//  Description : Buffers signed operand pairs and issues them one at a time
//                to a Booth multiplier, returning products over valid/ready.
//                Define BOOTH_SEQ_TIMEOUT_EN to enable the WAIT timeout / err.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module booth_operand_sequencer
    import booth_pkg::*;
#(
    parameter int W       = DEF_W,
    parameter int DEPTH   = DEF_DEPTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   in_x,
    input  logic [W-1:0]   in_y,
    output logic           mul_start,
    output logic [W-1:0]   mul_x,
    output logic [W-1:0]   mul_y,
    input  logic [2*W-1:0] mul_z,
    input  logic           mul_valid,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [2*W-1:0] res_z,
    output logic           err
);

    typedef struct packed {
        logic [W-1:0] x;
        logic [W-1:0] y;
    } op_pair_t;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("TIMEOUT must be at least 1");
    end

    op_pair_t               push_pair;
    op_pair_t               head_pair;
    logic                   fifo_push;
    logic                   fifo_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;

    state_t         state_q;
    state_t         state_d;
    logic [W-1:0]   mul_x_q;
    logic [W-1:0]   mul_x_d;
    logic [W-1:0]   mul_y_q;
    logic [W-1:0]   mul_y_d;
    logic [2*W-1:0] res_z_q;
    logic [2*W-1:0] res_z_d;
    logic           mul_valid_q;
    logic           mul_rise;
    logic           load_ops;
    logic           timed_out;

    assign in_ready  = !fifo_full;
    assign fifo_push = in_valid && in_ready;
    assign push_pair = {in_x, in_y};

    booth_operand_fifo #(
        .T     (op_pair_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata (push_pair),
        .pop   (fifo_pop),
        .rdata (head_pair),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // A valid already high on WAIT entry is a stale level, not a completion.
    assign mul_rise = mul_valid && !mul_valid_q;

`ifdef BOOTH_SEQ_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tmo_cnt_q;
    logic [CW-1:0] tmo_cnt_d;
    logic          err_q;

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == ST_ISSUE) begin
            tmo_cnt_d = '0;
        end else if (state_q == ST_WAIT && !mul_rise) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    assign timed_out = (state_q == ST_WAIT) && !mul_rise && (tmo_cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            err_q     <= timed_out;
        end
    end

    assign err = err_q;
`else
    assign timed_out = 1'b0;
    assign err       = 1'b0;
`endif

    // Operands are loaded on the edge entering ISSUE so they are already
    // stable while mul_start is high.
    always_comb begin
        state_d  = state_q;
        mul_x_d  = mul_x_q;
        mul_y_d  = mul_y_q;
        res_z_d  = res_z_q;
        fifo_pop = 1'b0;
        load_ops = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_d  = ST_ISSUE;
                    load_ops = 1'b1;
                end
            end
            ST_ISSUE: begin
                fifo_pop = (fifo_count != '0);
                state_d  = ST_WAIT;
            end
            ST_WAIT: begin
                if (mul_rise) begin
                    res_z_d = mul_z;
                    state_d = ST_HOLD;
                end else if (timed_out) begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (res_ready) begin
                    if (!fifo_empty) begin
                        state_d  = ST_ISSUE;
                        load_ops = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (load_ops) begin
            mul_x_d = head_pair.x;
            mul_y_d = head_pair.y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            mul_x_q     <= '0;
            mul_y_q     <= '0;
            res_z_q     <= '0;
            mul_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mul_x_q     <= mul_x_d;
            mul_y_q     <= mul_y_d;
            res_z_q     <= res_z_d;
            mul_valid_q <= mul_valid;
        end
    end

    assign mul_start = (state_q == ST_ISSUE);
    assign mul_x     = mul_x_q;
    assign mul_y     = mul_y_q;
    assign res_valid = (state_q == ST_HOLD);
    assign res_z     = res_z_q;

endmodule

`default_nettype wire
